// File: rtl/priority_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : priority_pkg
//  Description : Shared definitions for the priority decoder family.
//                - PRIO_LOW / PRIO_HIGH : legal values of LSB_PRIORITY
//                    "LOW"  -> MSB wins, mask covers bits [idx:0]
//                    "HIGH" -> LSB wins, mask covers bits [WIDTH-1:idx]
//                - idx_width()          : width of an encoded index for a
//                                         given number of unencoded bits
//  Revision    : 1.0  initial release
// ============================================================================
package priority_pkg;

  localparam string PRIO_LOW  = "LOW";
  localparam string PRIO_HIGH = "HIGH";

  // Number of bits needed to carry an index into a WIDTH-bit vector.
  // Never returns less than one bit, so degenerate widths still elaborate.
  function automatic int idx_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : priority_skid_buffer
//  Description : Two-entry valid/ready register slice (main output register
//                plus one skid register). Sustains one beat per cycle while
//                the sink is ready, and breaks the combinational path from
//                out_ready back to in_ready: in_ready is a flop that equals
//                the inverse of the skid occupancy.
//
//  Parameters  : DATA_WIDTH  payload width in bits
//
//  Ports       : clk        rising-edge clock
//                rst        synchronous active-high reset
//                in_data    upstream payload
//                in_valid   upstream beat present
//                in_ready   slice can accept a beat (registered)
//                out_data   downstream payload (held stable while stalled)
//                out_valid  downstream beat present
//                out_ready  downstream accepts the beat
//
//  Revision    : 1.0  initial release
// ============================================================================
module priority_skid_buffer #(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  skid_valid_reg;
  logic                  in_ready_reg;

  logic [DATA_WIDTH-1:0] out_data_next;
  logic                  out_valid_next;
  logic [DATA_WIDTH-1:0] skid_data_next;
  logic                  skid_valid_next;

  logic                  in_xfer;

  assign in_xfer = in_valid && in_ready_reg;

  always_comb begin
    out_data_next   = out_data_reg;
    out_valid_next  = out_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;

    if (!out_valid_reg || out_ready) begin
      // Output register is free (empty or draining this cycle). The skid
      // beat is older than anything on the input, so it goes first. While
      // the skid is full in_ready is low, so no input beat can collide.
      if (skid_valid_reg) begin
        out_data_next   = skid_data_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (in_xfer) begin
        out_data_next  = in_data;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (in_xfer) begin
      // Output is stalled: park the accepted beat in the skid register.
      skid_data_next  = in_data;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      // Ready tracks the skid occupancy one cycle later, so out_ready only
      // ever reaches in_ready through this flop.
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule
`default_nettype wire

// File: rtl/priority_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : priority_decoder
//  Description : Decodes an encoded index back to a one-hot vector and to the
//                mask of bits that could also be set without changing the
//                result of the matching priority encoder. The decode is
//                purely combinational and is registered by a two-entry skid
//                buffer, giving exactly one cycle of latency with full
//                valid/ready flow control.
//
//  Parameters  : WIDTH         number of unencoded bits (2..256)
//                LSB_PRIORITY  "LOW"  : MSB wins, mask = bits [idx:0]
//                              "HIGH" : LSB wins, mask = bits [WIDTH-1:idx]
//
//  Macro       : PRIORITY_DECODER_RANGE_CHECK_EN
//                defined   -> index >= WIDTH raises output_error
//                undefined -> output_error tied low
//                Either way an out-of-range index decodes to all-zero
//                unencoded/mask (only reachable when WIDTH is not a power
//                of two).
//
//  Ports       : clk               rising-edge clock
//                rst               synchronous active-high reset
//                input_encoded     index of the winning bit
//                input_valid       input beat present
//                input_ready       block accepts an input beat (registered)
//                output_unencoded  one-hot decode of the index
//                output_mask       bits that may be set without changing
//                                  the encoded result
//                output_error      beat carried an out-of-range index
//                output_valid      output beat present
//                output_ready      downstream accepts the output beat
//
//  Revision    : 1.0  initial release
// ============================================================================
module priority_decoder
  import priority_pkg::*;
#(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = PRIO_LOW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [idx_width(WIDTH)-1:0]  input_encoded,
  input  logic                         input_valid,
  output logic                         input_ready,
  output logic [WIDTH-1:0]             output_unencoded,
  output logic [WIDTH-1:0]             output_mask,
  output logic                         output_error,
  output logic                         output_valid,
  input  logic                         output_ready
);

  localparam int DATA_WIDTH = 2 * WIDTH + 1;

  logic [31:0]           idx_ext;
  logic                  in_range;
  logic [WIDTH-1:0]      dec_onehot;
  logic [WIDTH-1:0]      dec_mask;
  logic                  dec_error;
  logic [DATA_WIDTH-1:0] dec_payload;
  logic [DATA_WIDTH-1:0] out_payload;

  // Compare in 32 bits so the range test stays meaningful for any WIDTH.
  assign idx_ext  = 32'(input_encoded);
  assign in_range = (idx_ext < 32'(WIDTH));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign dec_onehot[i] = in_range && (idx_ext == 32'(i));
    if (LSB_PRIORITY == PRIO_HIGH) begin : g_high
      // LSB wins: anything at or above the winner leaves the result intact.
      assign dec_mask[i] = in_range && (32'(i) >= idx_ext);
    end else begin : g_low
      // MSB wins: anything at or below the winner leaves the result intact.
      assign dec_mask[i] = in_range && (32'(i) <= idx_ext);
    end
  end

`ifdef PRIORITY_DECODER_RANGE_CHECK_EN
  assign dec_error = !in_range;
`else
  assign dec_error = 1'b0;
`endif

  assign dec_payload = {dec_error, dec_mask, dec_onehot};

  priority_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (dec_payload),
    .in_valid  (input_valid),
    .in_ready  (input_ready),
    .out_data  (out_payload),
    .out_valid (output_valid),
    .out_ready (output_ready)
  );

  assign output_unencoded = out_payload[WIDTH-1:0];
  assign output_mask      = out_payload[2*WIDTH-1:WIDTH];
  assign output_error     = out_payload[2*WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_priority_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_decoder
//  Description : Self-checking bench. Three decoders share one stimulus
//                stream: WIDTH=4 "LOW", WIDTH=4 "HIGH" and WIDTH=5 "LOW".
//                A per-instance model (a queue of at most two beats with
//                payloads computed arithmetically) predicts valid, ready and
//                payload on every cycle; directed beats pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_priority_decoder;

`ifdef PRIORITY_DECODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] enc_a;   // index for the two WIDTH=4 instances
  logic [2:0] enc_b;   // index for the WIDTH=5 instance

  logic [3:0] u0, m0, u1, m1;
  logic [4:0] u2, m2;
  logic [NDUT-1:0] err, ov, ir;

  logic [7:0] une  [NDUT];
  logic [7:0] mask [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priority_decoder #(.WIDTH(4), .LSB_PRIORITY("LOW")) dut0 (
    .clk(clk), .rst(rst), .input_encoded(enc_a), .input_valid(in_valid),
    .input_ready(ir[0]), .output_unencoded(u0), .output_mask(m0),
    .output_error(err[0]), .output_valid(ov[0]), .output_ready(out_ready));

  priority_decoder #(.WIDTH(4), .LSB_PRIORITY("HIGH")) dut1 (
    .clk(clk), .rst(rst), .input_encoded(enc_a), .input_valid(in_valid),
    .input_ready(ir[1]), .output_unencoded(u1), .output_mask(m1),
    .output_error(err[1]), .output_valid(ov[1]), .output_ready(out_ready));

  priority_decoder #(.WIDTH(5), .LSB_PRIORITY("LOW")) dut2 (
    .clk(clk), .rst(rst), .input_encoded(enc_b), .input_valid(in_valid),
    .input_ready(ir[2]), .output_unencoded(u2), .output_mask(m2),
    .output_error(err[2]), .output_valid(ov[2]), .output_ready(out_ready));

  assign une[0] = 8'(u0);  assign mask[0] = 8'(m0);
  assign une[1] = 8'(u1);  assign mask[1] = 8'(m1);
  assign une[2] = 8'(u2);  assign mask[2] = 8'(m2);

  // Expected payload {error, mask, unencoded} straight from the rules.
  function automatic logic [16:0] model(input int w, input bit high, input int idx);
    logic [7:0] u;
    logic [7:0] m;
    logic       e;
    u = '0; m = '0; e = 1'b0;
    if (idx >= w) begin
      e = RC;
    end else begin
      u = 8'(1 << idx);
      if (high) m = 8'(((1 << w) - 1) - ((1 << idx) - 1));
      else      m = 8'((2 << idx) - 1);
    end
    return {e, m, u};
  endfunction

  function automatic int dut_width(input int d);
    return (d == 2) ? 5 : 4;
  endfunction

  function automatic int dut_idx(input int d);
    return (d == 2) ? int'(enc_b) : int'(enc_a);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model --
  logic [16:0] mq [NDUT][2];
  int          cnt [NDUT];
  bit          rst_seen;
  bit          was_stalled [NDUT];
  logic [16:0] prev_pl [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      cnt[d] = 0;
      was_stalled[d] = 1'b0;
      prev_pl[d] = '0;
    end
    rst_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        cnt[d] = 0;
        was_stalled[d] = 1'b0;
      end
      rst_seen = 1'b1;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        logic [16:0] act;
        act = {err[d], mask[d], une[d]};
        chk("valid", d, 32'(ov[d]), 32'(cnt[d] > 0));
        chk("ready", d, 32'(ir[d]), 32'(cnt[d] < 2));
        if (rst_seen) chk("reset_payload", d, 32'(act), 32'd0);
        if (cnt[d] > 0) chk("payload", d, 32'(act), 32'(mq[d][0]));
        if (was_stalled[d]) chk("stall_stable", d, 32'(act), 32'(prev_pl[d]));
        was_stalled[d] = (cnt[d] > 0) && !out_ready;
        prev_pl[d] = act;
        if (cnt[d] > 0 && out_ready) begin
          mq[d][0] = mq[d][1];
          cnt[d]--;
        end
        if (in_valid && ir[d]) begin
          if (cnt[d] >= 2) begin
            chk("overflow", d, 32'(cnt[d]), 32'd1);
          end else begin
            mq[d][cnt[d]] = model(dut_width(d), d == 1, dut_idx(d));
            cnt[d]++;
          end
        end
      end
      rst_seen = 1'b0;
    end
  end

  // ------------------------------------------------------------- stimulus --
  task automatic drive_one(input logic [1:0] a, input logic [2:0] b);
    in_valid = 1'b1;
    enc_a = a;
    enc_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int  k;
    int  cyc;
    int  beats;
    bit  acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; enc_a = '0; enc_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed beats with literal expectations.
    drive_one(2'd2, 3'd6);
    chk("w4low_idx2_une",   0, 32'(une[0]),  32'h04);
    chk("w4low_idx2_mask",  0, 32'(mask[0]), 32'h07);
    chk("w4low_idx2_valid", 0, 32'(ov[0]),   32'd1);
    chk("w4high_idx2_mask", 1, 32'(mask[1]), 32'h0C);
    chk("w5_idx6_une",      2, 32'(une[2]),  32'h00);
    chk("w5_idx6_mask",     2, 32'(mask[2]), 32'h00);
    chk("w5_idx6_err",      2, 32'(err[2]),  32'(RC));
    @(posedge clk); #1;
    drive_one(2'd1, 3'd4);
    chk("w4high_idx1_une",  1, 32'(une[1]),  32'h02);
    chk("w4high_idx1_mask", 1, 32'(mask[1]), 32'h0E);
    chk("w5_idx4_une",      2, 32'(une[2]),  32'h10);
    chk("w5_idx4_mask",     2, 32'(mask[2]), 32'h1F);
    chk("w5_idx4_err",      2, 32'(err[2]),  32'd0);
    @(posedge clk); #1;
    drive_one(2'd0, 3'd0);
    chk("w4high_idx0_mask", 1, 32'(mask[1]), 32'h0F);
    chk("w4low_idx0_mask",  0, 32'(mask[0]), 32'h01);
    @(posedge clk); #1;

    // Stream 0..3 against a 3-cycle output stall.
    k = 0; cyc = 0;
    out_ready = 1'b0; in_valid = 1'b1; enc_a = 2'd0; enc_b = 3'd0;
    while (k < 4 && cyc < 50) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        enc_a = 2'(k);
        enc_b = 3'(k);
        if (k == 4) in_valid = 1'b0;
      end
      out_ready = (cyc >= 3);
    end
    chk("stall_stream_done", 0, 32'(k), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Full-rate throughput with output_ready held high.
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enc_a = 2'($urandom);
      enc_b = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (in_valid && ir[0]) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_rate_beats", 0, 32'(k), 32'd20);
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    beats = 0; cyc = 0;
    in_valid = 1'b1; enc_a = 2'($urandom); enc_b = 3'($urandom_range(0, 7));
    while (beats < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      @(posedge clk); #1;
      cyc++;
      if (acc) beats++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        enc_a = 2'($urandom);
        enc_b = 3'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 1) != 0);
    end
    chk("random_beats_done", 0, 32'(beats), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Two beats held, then a one-cycle reset pulse.
    k = 0; cyc = 0;
    out_ready = 1'b0; in_valid = 1'b1; enc_a = 2'd3; enc_b = 3'd2;
    while (k < 2 && cyc < 20) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    chk("two_beats_held", 0, 32'(k), 32'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("post_reset_valid", d, 32'(ov[d]),   32'd0);
      chk("post_reset_ready", d, 32'(ir[d]),   32'd1);
      chk("post_reset_une",   d, 32'(une[d]),  32'd0);
      chk("post_reset_mask",  d, 32'(mask[d]), 32'd0);
      chk("post_reset_err",   d, 32'(err[d]),  32'd0);
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of unencoded bits; legal range 2..256.
REQ-002 SHALL have parameter LSB_PRIORITY, default "LOW": "LOW" = MSB wins, "HIGH" = LSB wins; matches the encoder convention.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port input_encoded  input  $clog2(WIDTH)  index of the winning bit.
REQ-006 SHALL have port input_valid  input  1  input beat present.
REQ-007 SHALL have port input_ready  output  1  block accepts input beat.
REQ-008 SHALL have port output_unencoded  output  WIDTH  one-hot decode of the index.
REQ-009 SHALL have port output_mask  output  WIDTH  bits that may be set without changing the encoded result.
REQ-010 SHALL have port output_error  output  1  beat carried an out-of-range index.
REQ-011 SHALL have port output_valid  output  1  output beat present.
REQ-012 SHALL have port output_ready  input  1  downstream accepts output beat.

Function
REQ-013 Input transfer SHALL occur on a cycle with input_valid && input_ready; output transfer on output_valid && output_ready.
REQ-014 output_unencoded SHALL equal 1 << input_encoded for in-range index (index < WIDTH).
REQ-015 For LSB_PRIORITY "LOW", output_mask SHALL have bits [idx:0] set; for "HIGH", bits [WIDTH-1:idx] set.
REQ-016 Latency SHALL be exactly one cycle: a beat accepted in cycle N is on the outputs, output_valid high, in cycle N+1.
REQ-017 Block SHALL hold a main output register plus one skid register (2 beats total); no beat is dropped or duplicated.
REQ-018 input_ready SHALL be registered and equal !skid_valid; no combinational path from output_ready to input_ready.
REQ-019 When output stalls (output_valid && !output_ready) and a beat is accepted, that beat SHALL go to the skid register.
REQ-020 When the output register transfers and skid is full, skid SHALL move to the output register in the same cycle and input_ready SHALL rise next cycle.
REQ-021 Simultaneous output transfer and input transfer with empty skid SHALL load the new beat directly into the output register.
REQ-022 Output payload SHALL remain stable while output_valid && !output_ready.
REQ-023 Beat order SHALL be strictly preserved.
REQ-024 Full-rate throughput (one beat per cycle) SHALL be sustained while output_ready is held high.

Reset
REQ-025 On rst, output_valid, skid_valid SHALL be 0; input_ready SHALL be 1 in the cycle after rst deasserts.
REQ-026 On rst, output_unencoded, output_mask SHALL be all zeros and output_error SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard both held beats; no transfer occurs in the reset cycle.

Configuration
REQ-028 Macro PRIORITY_DECODER_RANGE_CHECK_EN SHALL control out-of-range handling (only relevant when WIDTH is not a power of two).
REQ-029 With the macro defined, an index >= WIDTH SHALL produce a beat with output_unencoded = 0, output_mask = 0, output_error = 1.
REQ-030 Without the macro, an index >= WIDTH SHALL produce output_unencoded = 0, output_mask = 0, and output_error SHALL be tied 0.

Structure
REQ-031 Shared package priority_pkg SHALL hold the LSB_PRIORITY string constants and an index-width helper function (clog2 of WIDTH).
REQ-032 Skid buffer SHALL be one sub-module, priority_skid_buffer, parameterised on payload width (2*WIDTH+1).
REQ-033 Decode/mask logic SHALL be combinational ahead of the skid buffer; the module has no other state.

Verification
REQ-034 WIDTH=4, LOW, output_ready=1, input idx 2 -> next cycle unencoded 0100, mask 0111, valid 1.
REQ-035 WIDTH=4, HIGH, idx 1 -> unencoded 0010, mask 1110; idx 0 -> mask 1111.
REQ-036 Stream idx 0,1,2,3 with output_ready=0 for 3 cycles -> input_ready low after 2 beats accepted, then beats emerge 0,1,2,3 in order with no loss.
REQ-037 WIDTH=5, macro defined, idx 6 -> unencoded 00000, mask 00000, error 1; macro undefined -> same payload, error 0.
REQ-038 Two beats held, rst pulsed 1 cycle -> output_valid 0 and outputs zero next cycle; input_ready 1 after reset release.
REQ-039 output_ready toggled randomly over 1000 beats -> scoreboard exact match, payload stable during stalls.
